// File: rtl/spi_route_master.sv
// -----------------------------------------------------------------------------
// spi_route_master
//
// Purpose:
//   Serial master for an addressed SPI router. One transaction does this:
//     1. It shifts a 5-bit slave index into the router scan register, with
//        REGSEL=1.
//     2. It waits for a short gap, during which REGSEL drops.
//     3. It runs a full-duplex data phase of DATA_W bits, with REGSEL=0.
//     4. It ends with a short tail and a one-cycle done pulse.
//   Each bit period is 2*CLK_DIV cycles of Master_clk: SCLK is low for the
//   first half and high for the second half.
//
// Ports:
//   Master_clk  in   single clock; all state changes on its rising edge
//   RESET       in   asynchronous, active-low reset
//   start       in   transaction request; honoured only in IDLE
//   addr[4:0]   in   target slave index; captured on start
//   tx_data     in   word sent to the slave, MSB first; captured on start
//   SOUT        in   serial return line from the router
//   REGSEL      out  1 = address-scan mode, 0 = slave-data mode
//   SCLK        out  generated serial clock
//   SIN         out  serial data to the router
//   busy        out  high for the whole transaction body
//   done        out  one-cycle completion pulse, following the last busy cycle
//   rx_data     out  word captured from SOUT; updates only with done
//
// Every output comes straight from a flop.
// -----------------------------------------------------------------------------
module spi_route_master #(
    parameter int DATA_W  = 16,
    parameter int CLK_DIV = 4
) (
    input  logic              Master_clk,
    input  logic              RESET,
    input  logic              start,
    input  logic [4:0]        addr,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              SOUT,
    output logic              REGSEL,
    output logic              SCLK,
    output logic              SIN,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rx_data
);
    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W = 6;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] ADDR_LAST = BIT_W'(4);
    localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_GAP, S_DATA, S_TAIL, S_DONE
    } state_t;

    state_t             r_state,   w_state_next;
    logic [CNT_W-1:0]   r_cnt,     w_cnt_next;
    logic [BIT_W-1:0]   r_bit,     w_bit_next;
    logic [4:0]         r_addr,    w_addr_next;
    logic [DATA_W-1:0]  r_tx_sh,   w_tx_sh_next;
    logic [DATA_W-1:0]  r_rx_sh,   w_rx_sh_next;
    logic [DATA_W-1:0]  r_rx_data, w_rx_data_next;
    logic               r_regsel,  w_regsel_next;
    logic               r_sclk,    w_sclk_next;
    logic               r_sin,     w_sin_next;
    logic               r_busy,    w_busy_next;
    logic               r_done,    w_done_next;
    logic               w_half_end;
    logic [DATA_W-1:0]  w_tx_shl;

    assign w_half_end = (r_cnt == CNT_LAST);
    assign w_tx_shl   = r_tx_sh << 1;

    always_comb begin
        w_state_next   = r_state;
        w_cnt_next     = r_cnt;
        w_bit_next     = r_bit;
        w_addr_next    = r_addr;
        w_tx_sh_next   = r_tx_sh;
        w_rx_sh_next   = r_rx_sh;
        w_rx_data_next = r_rx_data;
        w_regsel_next  = 1'b0;
        w_sclk_next    = r_sclk;
        w_sin_next     = r_sin;
        w_busy_next    = r_busy;
        w_done_next    = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_sclk_next = 1'b0;
                w_sin_next  = 1'b0;
                w_busy_next = 1'b0;
                if (start) begin
                    w_state_next = S_ADDR;
                    w_addr_next  = addr;
                    w_tx_sh_next = tx_data;
                    w_cnt_next   = '0;
                    w_bit_next   = '0;
                    // Present the first address bit for the first low half.
                    w_sin_next   = addr[4];
                    w_busy_next  = 1'b1;
                end
            end
            S_ADDR: begin
                if (w_half_end) begin
                    w_cnt_next = '0;
                    if (!r_sclk) begin
                        w_sclk_next = 1'b1;
                    end else begin
                        w_sclk_next = 1'b0;
                        if (r_bit == ADDR_LAST) begin
                            // This falling edge latches the router decoder.
                            // REGSEL is still 1 here and drops one cycle later.
                            w_state_next = S_GAP;
                            w_bit_next   = '0;
                            w_sin_next   = 1'b0;
                        end else begin
                            w_bit_next = r_bit + 1'b1;
                            w_sin_next = r_addr[3'd3 - r_bit[2:0]];
                        end
                    end
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            S_GAP: begin
                if (w_half_end) begin
                    w_cnt_next   = '0;
                    w_state_next = S_DATA;
                    w_sin_next   = r_tx_sh[DATA_W-1];
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            S_DATA: begin
                if (w_half_end) begin
                    w_cnt_next = '0;
                    if (!r_sclk) begin
                        // SOUT is sampled on the same edge that raises SCLK.
                        w_sclk_next  = 1'b1;
                        w_rx_sh_next = (r_rx_sh << 1) | DATA_W'(SOUT);
                    end else begin
                        w_sclk_next = 1'b0;
                        if (r_bit == DATA_LAST) begin
                            w_state_next = S_TAIL;
                            w_sin_next   = 1'b0;
                        end else begin
                            w_bit_next   = r_bit + 1'b1;
                            w_tx_sh_next = w_tx_shl;
                            w_sin_next   = w_tx_shl[DATA_W-1];
                        end
                    end
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            S_TAIL: begin
                if (w_half_end) begin
                    w_cnt_next     = '0;
                    w_state_next   = S_DONE;
                    w_busy_next    = 1'b0;
                    w_done_next    = 1'b1;
                    w_rx_data_next = r_rx_sh;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
                w_busy_next  = 1'b0;
            end
        endcase

        // REGSEL is held through the first GAP cycle.
        // The router therefore sees the last address falling edge before mode changes.
        w_regsel_next = (w_state_next == S_ADDR) || (r_state == S_ADDR);
    end

    always_ff @(posedge Master_clk or negedge RESET) begin
        if (!RESET) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_bit     <= '0;
            r_addr    <= '0;
            r_tx_sh   <= '0;
            r_rx_sh   <= '0;
            r_rx_data <= '0;
            r_regsel  <= 1'b0;
            r_sclk    <= 1'b0;
            r_sin     <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_cnt     <= w_cnt_next;
            r_bit     <= w_bit_next;
            r_addr    <= w_addr_next;
            r_tx_sh   <= w_tx_sh_next;
            r_rx_sh   <= w_rx_sh_next;
            r_rx_data <= w_rx_data_next;
            r_regsel  <= w_regsel_next;
            r_sclk    <= w_sclk_next;
            r_sin     <= w_sin_next;
            r_busy    <= w_busy_next;
            r_done    <= w_done_next;
        end
    end

    assign REGSEL  = r_regsel;
    assign SCLK    = r_sclk;
    assign SIN     = r_sin;
    assign busy    = r_busy;
    assign done    = r_done;
    assign rx_data = r_rx_data;

endmodule
